// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV64I control sequencer driving datapath enables, mux selects and a shared memory port.
// Outputs are combinational from state and inputs; memory states stall until mem_ready.
module riscv_multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       alu_word,
  output logic       halted,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_WB     = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_NOP    = 4'd10,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  state_t     state, state_nxt;
  logic       illegal;
  logic       is_r;
  logic       alt;
  logic       word_op;
  logic [3:0] alu_op;
  logic       taken;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Instruction legality and ALU operation, valid whenever the IR fields are stable.
  always_comb begin
    illegal = 1'b0;
    is_r    = 1'b0;
    alt     = 1'b0;
    word_op = 1'b0;
    alu_op  = ALU_ADD;
    case (opcode)
      OP_R, OP_RW, OP_I, OP_IW: begin
        is_r    = (opcode == OP_R) || (opcode == OP_RW);
        word_op = (opcode == OP_RW) || (opcode == OP_IW);
        // I-type shifts carry shamt[5] in func7[0], so only the upper bits select SRA.
        alt     = is_r ? (func7 == 7'b0100000) : (func7[6:1] == 6'b010000);
        case (func3)
          3'b000:  alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        if (is_r && (func7 != 7'b0000000) && (func7 != 7'b0100000)) illegal = 1'b1;
        if (word_op && !(func3 inside {3'b000, 3'b001, 3'b101}))   illegal = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: illegal = 1'b0;
      OP_BR:   illegal = (func3 == 3'b010) || (func3 == 3'b011);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (func3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_ctrl  = ALU_ADD;
    alu_word  = 1'b0;
    halted    = 1'b0;
    state_dbg = state;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) state_nxt = ILLEGAL_HALT ? S_HALT : S_NOP;
        else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_nxt = S_ADDR;
            OP_BR:             state_nxt = S_BRANCH;
            OP_JAL, OP_JALR:   state_nxt = S_JUMP;
            default:           state_nxt = S_EXEC;
          endcase
        end
      end
      S_EXEC, S_WB: begin
        alu_ctrl  = alu_op;
        alu_word  = word_op;
        alu_src_a = (opcode == OP_AUIPC);
        alu_src_b = (opcode == OP_I) || (opcode == OP_IW) ||
                    (opcode == OP_LUI) || (opcode == OP_AUIPC);
        if (state == S_EXEC) state_nxt = S_WB;
        else begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          wb_sel    = (opcode == OP_LUI) ? 2'b11 : 2'b00;
          state_nxt = S_FETCH;
        end
      end
      S_ADDR: begin
        alu_src_b = 1'b1;
        state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        alu_src_b = 1'b1;
        mem_req   = 1'b1;
        mem_sel   = 1'b1;
        mem_we    = (state == S_MEM_WR);
        if (mem_ready) begin
          pc_write  = 1'b1;
          state_nxt = S_FETCH;
          if (state == S_MEM_RD) begin
            reg_write = 1'b1;
            wb_sel    = 2'b01;
          end
        end
      end
      S_BRANCH: begin
        alu_ctrl  = ALU_SUB;
        pc_write  = 1'b1;
        pc_src    = taken ? 2'b01 : 2'b00;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_src    = (opcode == OP_JALR) ? 2'b10 : 2'b01;
        state_nxt = S_FETCH;
      end
      S_NOP: begin
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_ctrl  = ALU_ADD;
      alu_word  = 1'b0;
      halted    = 1'b0;
      state_dbg = 4'd0;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: per-instruction cycle traces built from the instruction rules,
// replayed against a NOP-on-illegal instance and a HALT-on-illegal instance sharing the same inputs.
module tb_riscv_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, sel, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wbs;
    logic       a, b;
    logic [3:0] alu;
    logic       word, halt;
  } outv_t;

  typedef struct {
    bit         rst, rdy, z, lt, ltu;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    outv_t      e, eh;
  } cyc_t;

  typedef enum {K_ALU, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

  logic       clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;

  logic       req_n, we_n, sel_n, irw_n, pcw_n, rw_n, a_n, b_n, word_n, halt_n;
  logic [1:0] pcs_n, wbs_n;
  logic [3:0] alu_n, st_n;
  logic       req_h, we_h, sel_h, irw_h, pcw_h, rw_h, a_h, b_h, word_h, halt_h;
  logic [1:0] pcs_h, wbs_h;
  logic [3:0] alu_h, st_h;
  outv_t      act_n, act_h;

  assign act_n = {st_n, req_n, we_n, sel_n, irw_n, pcw_n, pcs_n, rw_n, wbs_n, a_n, b_n, alu_n, word_n, halt_n};
  assign act_h = {st_h, req_h, we_h, sel_h, irw_h, pcw_h, pcs_h, rw_h, wbs_h, a_h, b_h, alu_h, word_h, halt_h};

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(req_n), .mem_we(we_n), .mem_sel(sel_n), .ir_write(irw_n), .pc_write(pcw_n),
    .pc_src(pcs_n), .reg_write(rw_n), .wb_sel(wbs_n), .alu_src_a(a_n), .alu_src_b(b_n),
    .alu_ctrl(alu_n), .alu_word(word_n), .halted(halt_n), .state_dbg(st_n));

  riscv_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(req_h), .mem_we(we_h), .mem_sel(sel_h), .ir_write(irw_h), .pc_write(pcw_h),
    .pc_src(pcs_h), .reg_write(rw_h), .wb_sel(wbs_h), .alu_src_a(a_h), .alu_src_b(b_h),
    .alu_ctrl(alu_h), .alu_word(word_h), .halted(halt_h), .state_dbg(st_h));

  cyc_t q[$];
  bit   hm;  // HALT-on-illegal instance is parked in HALT
  int   ncmp = 0, nbad = 0;

  function automatic outv_t v(input logic [3:0] st);
    outv_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic outv_t haltv();
    outv_t o = v(4'd15);
    o.halt = 1'b1;
    return o;
  endfunction

  function automatic cyc_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input bit rdy, input outv_t e);
    cyc_t c;
    c.rst = 1'b0; c.rdy = rdy; c.op = op; c.f3 = f3; c.f7 = f7;
    c.z = 1'($urandom); c.lt = 1'($urandom); c.ltu = 1'($urandom);
    c.e = e;
    c.eh = hm ? haltv() : e;
    return c;
  endfunction

  // Instruction rules: class, ALU operation and W flag from the decoded fields.
  function automatic void mdec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               output kind_t k, output logic [3:0] alu, output logic word);
    logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    bit rgrp, igrp, alt;
    rgrp = (op == 7'h33) || (op == 7'h3b);
    igrp = (op == 7'h13) || (op == 7'h1b);
    word = (op == 7'h3b) || (op == 7'h1b);
    alu  = 4'd0;
    k    = K_ILL;
    if (rgrp || igrp) begin
      alt = rgrp ? (f7 == 7'h20) : (f7[6:1] == 6'h10);
      alu = base[f3];
      if (alt && (f3 == 3'd5 || (f3 == 3'd0 && rgrp))) alu = alu + 4'd1;
      k = K_ALU;
      if (rgrp && f7 != 7'h00 && f7 != 7'h20) k = K_ILL;
      if (word && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) k = K_ILL;
    end else begin
      case (op)
        7'h37: k = K_LUI;
        7'h17: k = K_AUIPC;
        7'h03: k = K_LOAD;
        7'h23: k = K_STORE;
        7'h63: k = (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
        7'h6f: k = K_JAL;
        7'h67: k = K_JALR;
        default: k = K_ILL;
      endcase
    end
    if (k == K_ILL) begin alu = 4'd0; word = 1'b0; end
  endfunction

  // Appends the expected trace of one instruction; fw/mw are memory wait cycles,
  // zf forces alu_zero in BRANCH (-1 = random), rst_at replaces that cycle with a reset.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input int fw, input int mw, input int zf, input int rst_at, output int len);
    cyc_t t[$];
    cyc_t c;
    outv_t x, y;
    kind_t k;
    logic [3:0] alu;
    logic word;
    bit tk;
    mdec(op, f3, f7, k, alu, word);
    for (int j = 0; j <= fw; j++) begin
      x = v(4'd0); x.req = 1'b1; x.irw = (j == fw);
      t.push_back(mk(7'($urandom), 3'($urandom), 7'($urandom), j == fw, x));
    end
    t.push_back(mk(op, f3, f7, 1'($urandom), v(4'd1)));
    case (k)
      K_ALU, K_LUI, K_AUIPC: begin
        x = v(4'd2); x.alu = alu; x.word = word;
        x.a = (k == K_AUIPC);
        x.b = (k != K_ALU) || op == 7'h13 || op == 7'h1b;
        t.push_back(mk(op, f3, f7, 1'($urandom), x));
        y = x; y.st = 4'd3; y.rw = 1'b1; y.pcw = 1'b1; y.wbs = (k == K_LUI) ? 2'd3 : 2'd0;
        t.push_back(mk(op, f3, f7, 1'($urandom), y));
      end
      K_LOAD, K_STORE: begin
        x = v(4'd4); x.b = 1'b1;
        t.push_back(mk(op, f3, f7, 1'($urandom), x));
        x.st = (k == K_LOAD) ? 4'd5 : 4'd7; x.req = 1'b1; x.sel = 1'b1; x.we = (k == K_STORE);
        for (int j = 0; j <= mw; j++) begin
          y = x;
          if (j == mw) begin
            y.pcw = 1'b1;
            if (k == K_LOAD) begin y.rw = 1'b1; y.wbs = 2'd1; end
          end
          t.push_back(mk(op, f3, f7, j == mw, y));
        end
      end
      K_BR: begin
        c = mk(op, f3, f7, 1'($urandom), '0);
        if (zf >= 0) c.z = zf[0];
        case (f3)
          3'd0: tk = c.z;   3'd1: tk = !c.z;
          3'd4: tk = c.lt;  3'd5: tk = !c.lt;
          3'd6: tk = c.ltu; default: tk = !c.ltu;
        endcase
        x = v(4'd8); x.alu = 4'd1; x.pcw = 1'b1; x.pcs = tk ? 2'd1 : 2'd0;
        c.e = x; c.eh = hm ? haltv() : x;
        t.push_back(c);
      end
      K_JAL, K_JALR: begin
        x = v(4'd9); x.rw = 1'b1; x.wbs = 2'd2; x.pcw = 1'b1; x.pcs = (k == K_JALR) ? 2'd2 : 2'd1;
        t.push_back(mk(op, f3, f7, 1'($urandom), x));
      end
      default: begin
        hm = 1'b1;
        x = v(4'd10); x.pcw = 1'b1;
        t.push_back(mk(op, f3, f7, 1'($urandom), x));
      end
    endcase
    len = t.size();
    if (rst_at >= 0 && rst_at < t.size()) begin
      while (t.size() > rst_at) void'(t.pop_back());
      c = mk(op, f3, f7, 1'b0, '0);
      c.rst = 1'b1; c.eh = '0;
      t.push_back(c);
      hm = 1'b0;
    end
    foreach (t[j]) q.push_back(t[j]);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmpv(input string name, input outv_t act, input outv_t exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int    len;
    kind_t k;
    logic [3:0] alu;
    logic  word;
    logic [6:0] ops [13] = '{7'h33, 7'h3b, 7'h13, 7'h1b, 7'h37, 7'h17, 7'h03,
                             7'h23, 7'h63, 7'h6f, 7'h67, 7'h3b, 7'h00};
    logic [6:0] op, f7;
    cyc_t  c;

    hm = 1'b0;
    for (int j = 0; j < 2; j++) begin
      c = mk(7'd0, 3'd0, 7'd0, 1'b0, '0);
      c.rst = 1'b1; c.eh = '0;
      q.push_back(c);
    end

    mdec(7'h13, 3'd5, 7'h21, k, alu, word);
    chk("dec_srai_alu", int'(alu), 7);
    mdec(7'h3b, 3'd0, 7'h20, k, alu, word);
    chk("dec_subw_alu", int'(alu), 1);
    chk("dec_subw_word", int'(word), 1);
    mdec(7'h3b, 3'd6, 7'h00, k, alu, word);
    chk("dec_orw_illegal", int'(k == K_ILL), 1);

    build(7'h33, 3'd0, 7'h00, 0, 0, -1, -1, len);  chk("lat_add", len, 4);
    build(7'h03, 3'd3, 7'h00, 0, 3, -1, -1, len);  chk("lat_load_w3", len, 7);
    build(7'h63, 3'd0, 7'h00, 0, 0, 1, -1, len);   chk("lat_beq", len, 3);
    chk("beq_taken_pcs", int'(q[q.size()-1].e.pcs), 1);
    build(7'h63, 3'd1, 7'h00, 0, 0, 1, -1, len);   chk("lat_bne", len, 3);
    chk("bne_not_taken_pcs", int'(q[q.size()-1].e.pcs), 0);
    build(7'h13, 3'd5, 7'h21, 0, 0, -1, -1, len);
    build(7'h3b, 3'd0, 7'h20, 1, 0, -1, -1, len);
    build(7'h3b, 3'd6, 7'h00, 0, 0, -1, -1, len);  chk("lat_orw_nop", len, 3);
    build(7'h7f, 3'd0, 7'h00, 0, 0, -1, -1, len);  chk("lat_ill_nop", len, 3);
    build(7'h33, 3'd7, 7'h00, 0, 0, -1, -1, len);
    build(7'h37, 3'd0, 7'h00, 2, 0, -1, -1, len);
    build(7'h6f, 3'd0, 7'h00, 0, 0, -1, -1, len);  chk("lat_jal", len, 3);
    build(7'h23, 3'd2, 7'h00, 0, 3, -1, 4, len);   chk("lat_store_w3", len, 7);

    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 12)];
      if (op == 7'h00) op = 7'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h21;
        default: f7 = 7'($urandom);
      endcase
      build(op, 3'($urandom), f7, $urandom_range(0, 2), $urandom_range(0, 3), -1,
            ($urandom_range(0, 29) == 0) ? $urandom_range(0, 6) : -1, len);
    end

    foreach (q[i]) begin
      @(posedge clk); #1;
      reset     = q[i].rst;
      mem_ready = q[i].rdy;
      opcode    = q[i].op;
      func3     = q[i].f3;
      func7     = q[i].f7;
      alu_zero  = q[i].z;
      alu_lt    = q[i].lt;
      alu_ltu   = q[i].ltu;
      @(negedge clk);
      cmpv($sformatf("cyc%0d_nop_inst", i), act_n, q[i].e);
      cmpv($sformatf("cyc%0d_halt_inst", i), act_h, q[i].eh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle sequencer for the RV64I core datapath. It takes the opcode, func3 and func7 fields that the instruction decoder splits out of the instruction register (IR). Each instruction then runs through fetch / decode / execute / memory / writeback states. In every state the block drives the datapath enables, the mux selects and the memory request handshake. It replaces per-instruction single-cycle control so that one shared memory port serves both instruction and data accesses.

## Interface
Parameters:
- ILLEGAL_HALT, 1: on an illegal encoding, 1 = enter HALT (sticky until reset); 0 = treat the instruction as a NOP.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  from decoder (IR[6:0]); stable from DECODE until the instruction retires.
- func3  in  3  from decoder (IR[14:12]).
- func7  in  7  from decoder (IR[31:25]).
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU compare flags (equal, signed less-than, unsigned less-than).
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_sel  out  1  address source: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC+4, 11 = immediate (LUI).
- alu_src_a  out  1  ALU operand A: 0 = rs1, 1 = PC.
- alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- alu_ctrl  out  4  ALU operation: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- alu_word  out  1  32-bit W-op with sign-extended result.
- halted  out  1  1 while in HALT.
- state_dbg  out  4  current state encoding.

## Operation
State encodings: FETCH 0, DECODE 1, EXEC 2, WB 3, ADDR 4, MEM_RD 5, MEM_WR 7, BRANCH 8, JUMP 9, NOP 10, HALT 15.

- FETCH: mem_req=1, mem_sel=0, mem_we=0. On mem_ready: ir_write=1 and go to DECODE; otherwise stay.
- DECODE: no enables asserted. Dispatch on opcode:
  - 0110011, 0111011, 0010011, 0011011, 0110111, 0010111 → EXEC.
  - 0000011, 0100011 → ADDR.
  - 1100011 → BRANCH.
  - 1101111, 1100111 → JUMP.
  - Anything else is illegal.
- EXEC then WB: both states hold the same ALU controls.
  - WB additionally asserts reg_write=1 and pc_write=1 with pc_src=00, then goes to FETCH.
  - AUIPC uses alu_src_a=1, alu_src_b=1, ADD. LUI uses wb_sel=11.
- ALU decode for R-type and I-type:
  - func3 000: ADD; SUB only for R-type with func7=0100000.
  - func3 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 110: OR. 111: AND.
  - func3 101: SRL, or SRA when func7=0100000. For I-type shifts only func7[6:1] is compared, because func7[0] is shamt[5].
  - R-type func7 values other than 0000000 or 0100000 are illegal.
  - W opcodes (0111011, 0011011) set alu_word=1. They allow only ADD, SUB, SLL, SRL and SRA; any other func3 is illegal.
- ADDR: ADD with alu_src_b=1. Next state is MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_req=1, mem_sel=1, mem_we=0. On mem_ready: reg_write=1, wb_sel=01, pc_write=1, pc_src=00, then FETCH.
- MEM_WR: mem_req=1, mem_sel=1, mem_we=1. On mem_ready: pc_write=1, pc_src=00, then FETCH.
- BRANCH: ALU does SUB with alu_src_b=0. pc_write=1, with pc_src=01 if taken, else 00. Then FETCH.
  - Taken conditions by func3: 000 alu_zero; 001 !alu_zero; 100 alu_lt; 101 !alu_lt; 110 alu_ltu; 111 !alu_ltu.
  - func3 010 and 011 are illegal.
- JUMP: reg_write=1, wb_sel=10, pc_write=1. pc_src is 01 for JAL, 10 for JALR. Then FETCH.
- Illegal encodings, detected in DECODE:
  - ILLEGAL_HALT=1 → HALT. halted=1, all enables 0, and the block stays there until reset.
  - ILLEGAL_HALT=0 → NOP. pc_write=1, pc_src=00, then FETCH.
- Writes to x0 are not suppressed here; the register file ignores them.

## Timing
- Outputs are combinational from state and inputs, forced to 0 while reset=1.
- Reset values: state=FETCH; all outputs 0, state_dbg=0.
- Reset in any state, including mid-memory-wait or HALT: the next cycle is FETCH. Any pending memory request is abandoned with no write-back or PC update.
- mem_req, mem_we and mem_sel are held constant from request until the mem_ready cycle. Every memory state lasts at least 1 cycle.
- mem_ready while mem_req=0 is ignored.
- ALU selects and alu_ctrl are held constant across EXEC→WB and ADDR→MEM_*, so combinational results stay valid.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - ALU / LUI / AUIPC: 4 cycles.
  - Load, store: 4 cycles.
  - Branch, JAL, JALR: 3 cycles.
  - NOP (illegal, ILLEGAL_HALT=0): 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Exactly one pc_write pulse per retired instruction, and at most one reg_write pulse.

## Test plan
- Reset release, mem_ready=1, IR=ADD (opcode 0110011, func3 000, func7 0): state_dbg sequence 0,1,2,3,0. alu_ctrl=0000. reg_write and pc_write pulse once in state 3 with pc_src=00.
- Load (0000011) with mem_ready delayed 3 cycles in MEM_RD: mem_req/mem_sel=1 held for 4 cycles. reg_write=1 and wb_sel=01 only on the mem_ready cycle. Total 7 cycles.
- BEQ with alu_zero=1 then BNE with alu_zero=1: first gives pc_src=01, second gives pc_src=00. Each BRANCH state lasts 1 cycle and no reg_write occurs.
- SRAI (0010011, func3 101, func7 0100001) → alu_ctrl=0111. SUBW (0111011, func7 0100000) → alu_ctrl=0001 with alu_word=1. ORW-like encoding (0111011, func3 110) → illegal.
- Opcode 1111111 with ILLEGAL_HALT=1: halted=1 and the block stays in HALT for 10+ cycles with all enables 0. With ILLEGAL_HALT=0: NOP path, one pc_write pulse, back to FETCH.
- Assert reset in MEM_WR while mem_ready=0: mem_req=0 during the reset cycle. Next cycle is FETCH (state_dbg=0) with no pc_write.
